// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Optional feature macro used by hazard_ctrl: HAZ_PERF_CNT_EN (stall cycle counter).
package hazard_pkg;

    localparam int unsigned MD_CNT_W = 4;

    localparam logic [MD_CNT_W-1:0] MULT_LAT = 4'd5;
    localparam logic [MD_CNT_W-1:0] DIV_LAT  = 4'd10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    // True when a non-zero destination feeds one of the sources actually read in D.
    function automatic logic src_hit(
        input logic [4:0] rd,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       use_rs,
        input logic       use_rt
    );
        return (rd != REG_ZERO) && ((use_rs && (rs == rd)) || (use_rt && (rt == rd)));
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// HI/LO unit busy timer: a down-counter loaded with the operation latency on issue.
//
// state | meaning
// IDLE  | md_cnt == 0, HI/LO free, a new mult/div may be accepted
// BUSY  | md_cnt != 0, operation in flight, counting down once per clock
module md_busy_timer
    import hazard_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                md_start_E,
    input  logic                md_is_div_E,
    input  logic                flush_req,
    output logic                md_busy,
    output logic [MD_CNT_W-1:0] md_cnt
);

    md_state_t state;

    // Timer FSM; md_busy is kept as a register so it has no path from the inputs.
    // A flush only blocks a new issue; an operation already in BUSY runs to completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            md_cnt  <= '0;
            md_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (md_start_E && !flush_req) begin
                        md_cnt  <= md_is_div_E ? DIV_LAT : MULT_LAT;
                        md_busy <= 1'b1;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    md_cnt <= md_cnt - 1'b1;
                    if (md_cnt == 4'd1) begin
                        md_busy <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    md_cnt  <= '0;
                    md_busy <= 1'b0;
                end
            endcase
        end
    end

    // A second issue while busy is ignored; the D-stage stall should make it impossible.
    a_no_start_while_busy : assert property (
        @(posedge clk) disable iff (!reset_n) !(md_start_E && (state == BUSY))
    );

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch-operand and HI/LO-busy stalls plus
// flush handling, producing PC / F-D enables and F-D / D-E clears.
// Optional feature macro: HAZ_PERF_CNT_EN adds a 32-bit stall cycle counter output.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic [4:0]          rs_D,
    input  logic [4:0]          rt_D,
    input  logic                use_rs_D,
    input  logic                use_rt_D,
    input  logic                branch_D,
    input  logic [4:0]          rd_E,
    input  logic                regwrite_E,
    input  logic                memread_E,
    input  logic [4:0]          rd_M,
    input  logic                memread_M,
    input  logic                md_use_D,
    input  logic                md_start_E,
    input  logic                md_is_div_E,
    input  logic                flush_req,
    output logic                en_PC,
    output logic                en_FD,
    output logic                clr_FD,
    output logic                clr_DE,
    output logic                md_busy,
    output logic [MD_CNT_W-1:0] md_cnt
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]         stall_cnt
`endif
);

    logic hit_E;
    logic hit_M;
    logic load_use;
    logic br_haz;
    logic md_haz;
    logic stall;

    md_busy_timer u_md_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .md_start_E  (md_start_E),
        .md_is_div_E (md_is_div_E),
        .flush_req   (flush_req),
        .md_busy     (md_busy),
        .md_cnt      (md_cnt)
    );

    // Hazard detection; purely combinational so a stall acts in the same cycle.
    // md_start_E counts as busy so an instruction right behind an issue also waits.
    always_comb begin
        hit_E    = src_hit(rd_E, rs_D, rt_D, use_rs_D, use_rt_D);
        hit_M    = src_hit(rd_M, rs_D, rt_D, use_rs_D, use_rt_D);
        load_use = memread_E && regwrite_E && hit_E;
        br_haz   = branch_D && ((regwrite_E && hit_E) || (memread_M && hit_M));
        md_haz   = md_use_D && (md_busy || md_start_E);
        stall    = load_use || br_haz || md_haz;
    end

    // Enable/clear decode: flush beats stall; reset forces free-running outputs.
    always_comb begin
        en_PC  = 1'b1;
        en_FD  = 1'b1;
        clr_FD = 1'b0;
        clr_DE = 1'b0;
        if (reset_n) begin
            if (flush_req) begin
                clr_FD = 1'b1;
                clr_DE = 1'b1;
            end else if (stall) begin
                en_PC  = 1'b0;
                en_FD  = 1'b0;
                clr_DE = 1'b1;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    // Stall cycle counter; wraps naturally from all-ones to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (stall && !flush_req) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, branch, HI/LO busy timing, flush and reset.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] rs_D, rt_D, rd_E, rd_M;
    logic       use_rs_D, use_rt_D, branch_D;
    logic       regwrite_E, memread_E, memread_M;
    logic       md_use_D, md_start_E, md_is_div_E, flush_req;
    logic       en_PC, en_FD, clr_FD, clr_DE, md_busy;
    logic [3:0] md_cnt;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    logic [3:0] ctrl;
    assign ctrl = {en_PC, en_FD, clr_FD, clr_DE};

    localparam logic [3:0] NORM  = 4'b1100;
    localparam logic [3:0] STALL = 4'b0001;
    localparam logic [3:0] FLUSH = 4'b1111;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_stalls = 0;

    hazard_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rs_D        (rs_D),
        .rt_D        (rt_D),
        .use_rs_D    (use_rs_D),
        .use_rt_D    (use_rt_D),
        .branch_D    (branch_D),
        .rd_E        (rd_E),
        .regwrite_E  (regwrite_E),
        .memread_E   (memread_E),
        .rd_M        (rd_M),
        .memread_M   (memread_M),
        .md_use_D    (md_use_D),
        .md_start_E  (md_start_E),
        .md_is_div_E (md_is_div_E),
        .flush_req   (flush_req),
        .en_PC       (en_PC),
        .en_FD       (en_FD),
        .clr_FD      (clr_FD),
        .clr_DE      (clr_DE),
        .md_busy     (md_busy),
        .md_cnt      (md_cnt)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; st marks that the edge should count as a stall cycle.
    task automatic tick(input bit st);
        @(posedge clk);
        #1;
        if (st) exp_stalls++;
    endtask

    task automatic idle_inputs();
        rs_D = 5'd0; rt_D = 5'd0; use_rs_D = 1'b0; use_rt_D = 1'b0; branch_D = 1'b0;
        rd_E = 5'd0; regwrite_E = 1'b0; memread_E = 1'b0;
        rd_M = 5'd0; memread_M = 1'b0;
        md_use_D = 1'b0; md_start_E = 1'b0; md_is_div_E = 1'b0; flush_req = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;

        // Reset: a pending md hazard must not show while reset is held
        md_use_D = 1'b1; md_start_E = 1'b1;
        #12;
        check("rst_ctrl", 32'(ctrl), 32'(NORM));
        check("rst_cnt", 32'(md_cnt), 32'd0);
        check("rst_busy", 32'(md_busy), 32'd0);
        tick(0);
        check("rst_hold_cnt", 32'(md_cnt), 32'd0);
        idle_inputs();
        reset_n = 1'b1;
        tick(0);
        check("idle_ctrl", 32'(ctrl), 32'(NORM));

        // Load to $t0 in E, D reads rs=8
        rd_E = 5'd8; regwrite_E = 1'b1; memread_E = 1'b1;
        rs_D = 5'd8; use_rs_D = 1'b1;
        #1 check("lu_rs", 32'(ctrl), 32'(STALL));
        tick(1);
        rd_E = 5'd0; regwrite_E = 1'b0; memread_E = 1'b0;
        #1 check("lu_after", 32'(ctrl), 32'(NORM));

        // Load-use through rt, and an unused rt that matches
        rd_E = 5'd8; regwrite_E = 1'b1; memread_E = 1'b1;
        rs_D = 5'd3; use_rs_D = 1'b1; rt_D = 5'd8; use_rt_D = 1'b1;
        #1 check("lu_rt", 32'(ctrl), 32'(STALL));
        use_rt_D = 1'b0;
        #1 check("lu_rt_unused", 32'(ctrl), 32'(NORM));

        // Load to $zero never stalls
        rd_E = 5'd0; rs_D = 5'd0; use_rs_D = 1'b1;
        #1 check("lu_zero", 32'(ctrl), 32'(NORM));
        tick(0);
        idle_inputs();

        // Branch on rs=9 with an ALU write to $t1 in E
        branch_D = 1'b1; rs_D = 5'd9; use_rs_D = 1'b1;
        rd_E = 5'd9; regwrite_E = 1'b1;
        #1 check("br_alu_E", 32'(ctrl), 32'(STALL));
        tick(1);
        rd_E = 5'd0; regwrite_E = 1'b0;
        #1 check("br_alu_done", 32'(ctrl), 32'(NORM));
        // Same branch with a load to $t1 in M
        rd_M = 5'd9; memread_M = 1'b1;
        #1 check("br_load_M", 32'(ctrl), 32'(STALL));
        tick(1);
        rd_M = 5'd0; memread_M = 1'b0;
        #1 check("br_load_done", 32'(ctrl), 32'(NORM));
        // ALU write to $t1 with no branch in D is forwarded, not stalled
        branch_D = 1'b0; rd_E = 5'd9; regwrite_E = 1'b1;
        #1 check("alu_no_branch", 32'(ctrl), 32'(NORM));
        tick(0);
        idle_inputs();

        // Flush coinciding with a load-use hazard
        rd_E = 5'd8; regwrite_E = 1'b1; memread_E = 1'b1;
        rs_D = 5'd8; use_rs_D = 1'b1; flush_req = 1'b1;
        #1 check("flush_wins", 32'(ctrl), 32'(FLUSH));
        tick(0);
        idle_inputs();

        // Mult issue followed by mflo: six stall cycles, md_cnt 5..0
        md_start_E = 1'b1; md_is_div_E = 1'b0; md_use_D = 1'b1;
        #1 check("mult_issue_ctrl", 32'(ctrl), 32'(STALL));
        check("mult_issue_cnt", 32'(md_cnt), 32'd0);
        tick(1);
        md_start_E = 1'b0;
        for (int i = 5; i >= 1; i--) begin
            #1 check($sformatf("mult_cnt_%0d", i), 32'(md_cnt), 32'(i));
            check($sformatf("mult_busy_%0d", i), 32'(md_busy), 32'd1);
            check($sformatf("mult_stall_%0d", i), 32'(ctrl), 32'(STALL));
            tick(1);
        end
        check("mult_end_cnt", 32'(md_cnt), 32'd0);
        check("mult_end_busy", 32'(md_busy), 32'd0);
        check("mult_end_ctrl", 32'(ctrl), 32'(NORM));
        idle_inputs();

        // A flushed div issue never starts the timer
        md_start_E = 1'b1; md_is_div_E = 1'b1; flush_req = 1'b1;
        #1 check("div_flush_ctrl", 32'(ctrl), 32'(FLUSH));
        tick(0);
        idle_inputs();
        #1 check("div_flush_cnt", 32'(md_cnt), 32'd0);

        // Div issue followed by mfhi; a flush mid-operation does not cancel it
        md_start_E = 1'b1; md_is_div_E = 1'b1; md_use_D = 1'b1;
        #1 check("div_issue_ctrl", 32'(ctrl), 32'(STALL));
        tick(1);
        md_start_E = 1'b0; md_is_div_E = 1'b0;
        for (int i = 10; i >= 1; i--) begin
            #1 check($sformatf("div_cnt_%0d", i), 32'(md_cnt), 32'(i));
            if (i == 7) begin
                flush_req = 1'b1;
                #1 check("div_flush_mid", 32'(ctrl), 32'(FLUSH));
                tick(0);
                flush_req = 1'b0;
            end else begin
                check($sformatf("div_stall_%0d", i), 32'(ctrl), 32'(STALL));
                tick(1);
            end
        end
        check("div_end_cnt", 32'(md_cnt), 32'd0);
        check("div_end_busy", 32'(md_busy), 32'd0);
        check("div_end_ctrl", 32'(ctrl), 32'(NORM));
        idle_inputs();

`ifdef HAZ_PERF_CNT_EN
        #1 check("perf_total", stall_cnt, 32'(exp_stalls));
`endif

        // Second div, reset asserted when md_cnt reaches 4
        md_start_E = 1'b1; md_is_div_E = 1'b1; md_use_D = 1'b1;
        tick(1);
        md_start_E = 1'b0; md_is_div_E = 1'b0;
        for (int i = 10; i >= 5; i--) tick(1);
        check("div2_cnt_4", 32'(md_cnt), 32'd4);
        reset_n = 1'b0;
        exp_stalls = 0;
        #1 check("async_rst_cnt", 32'(md_cnt), 32'd0);
        check("async_rst_busy", 32'(md_busy), 32'd0);
        check("async_rst_ctrl", 32'(ctrl), 32'(NORM));
        tick(0);
        check("rst_held_cnt", 32'(md_cnt), 32'd0);
        md_use_D = 1'b0;
        reset_n = 1'b1;
        tick(0);
        check("post_rst_cnt", 32'(md_cnt), 32'd0);
        check("post_rst_ctrl", 32'(ctrl), 32'(NORM));

`ifdef HAZ_PERF_CNT_EN
        check("perf_after_rst", stall_cnt, 32'd0);
        rd_E = 5'd8; regwrite_E = 1'b1; memread_E = 1'b1;
        rs_D = 5'd8; use_rs_D = 1'b1;
        tick(1);
        idle_inputs();
        #1 check("perf_one", stall_cnt, 32'(exp_stalls));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
